// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational add/subtract unit among NUM_REQ
// requesters, with a single registered, tagged, backpressured response slot.
module addsub_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          module_clk_i,
  input  logic                          module_rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]            req_ci_i,
  input  logic [NUM_REQ-1:0]            req_add_sub_i,
  output logic                          asu_en_o,
  output logic [DATA_WIDTH-1:0]         asu_a_o,
  output logic [DATA_WIDTH-1:0]         asu_b_o,
  output logic                          asu_ci_o,
  output logic                          asu_add_sub_o,
  input  logic [DATA_WIDTH-1:0]         asu_sum_i,
  input  logic                          asu_co_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [ID_W-1:0]               resp_id_o,
  output logic [DATA_WIDTH-1:0]         resp_sum_o,
  output logic                          resp_co_o,
  output logic [31:0]                   op_count_o
);

  localparam int unsigned LAST = NUM_REQ - 1;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            slot_free;
  logic            grant;

  assign slot_free = !resp_valid_o || resp_ready_i;
  assign grant     = found && slot_free;

  // First valid requester at or after ptr, searching modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Unit operands are forced to zero whenever nothing is granted
  always_comb begin
    req_ready_o   = '0;
    asu_en_o      = 1'b0;
    asu_a_o       = '0;
    asu_b_o       = '0;
    asu_ci_o      = 1'b0;
    asu_add_sub_o = 1'b0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
      asu_en_o            = 1'b1;
      asu_a_o             = req_a_i[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
      asu_b_o             = req_b_i[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
      asu_ci_o            = req_ci_i[winner];
      asu_add_sub_o       = req_add_sub_i[winner];
    end
  end

  // Response slot: a grant overwrites it even while it drains, so no bubble
  always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
    if (!module_rst_ni) begin
      ptr          <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_sum_o   <= '0;
      resp_co_o    <= 1'b0;
      op_count_o   <= '0;
    end else if (grant) begin
      ptr          <= (winner == ID_W'(LAST)) ? '0 : winner + ID_W'(1);
      resp_valid_o <= 1'b1;
      resp_id_o    <= winner;
      resp_sum_o   <= asu_sum_i;
      resp_co_o    <= asu_co_i;
      op_count_o   <= op_count_o + 32'd1;
    end else if (resp_valid_o && resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter that shares one combinational `ADDSUB` add/subtract unit among `NUM_REQ` requesters inside the ALU. Each accepted request drives the unit for exactly one cycle with its enable asserted, and the result is captured into a single output register. The result is then returned on one response channel tagged with the requester index, with full valid/ready backpressure. The unit's enable is held low in idle cycles, so its operands are forced to zero there.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index. Derived; do not override.
- `module_clk_i`  in  1: clock. All state updates on the rising edge.
- `module_rst_ni`  in  1: reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ: per-requester request valid.
- `req_ready_o`  out  NUM_REQ: per-requester accept; at most one bit set per cycle.
- `req_a_i`, `req_b_i`  in  NUM_REQ*DATA_WIDTH: packed operands; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_ci_i`  in  NUM_REQ: carry/borrow in.
- `req_add_sub_i`  in  NUM_REQ: 0 = add, 1 = subtract (the unit's own convention).
- `asu_en_o`  out  1: enable to the shared unit.
- `asu_a_o`, `asu_b_o`  out  DATA_WIDTH: operands to the unit.
- `asu_ci_o`, `asu_add_sub_o`  out  1: carry in and operation select to the unit.
- `asu_sum_i`  in  DATA_WIDTH; `asu_co_i`  in  1: combinational result from the unit.
- `resp_valid_o`  out  1: response valid.
- `resp_ready_i`  in  1: response accept.
- `resp_id_o`  out  ID_W: index of the requester that owns the response.
- `resp_sum_o`  out  DATA_WIDTH; `resp_co_o`  out  1: registered result.
- `op_count_o`  out  32: number of accepted requests, wrapping.

## Operation
- **Slot free.** `slot_free = !resp_valid_o || resp_ready_i`. A grant is issued only when `slot_free` is 1.
- **Arbitration.** Combinational round-robin over `req_valid_i`, starting at priority pointer `ptr`.
  - The winner is the first valid index at or after `ptr`, searching modulo NUM_REQ.
  - `req_ready_o[w] = slot_free`; all other ready bits are 0.
- **Datapath drive in the grant cycle.**
  - `asu_en_o` = 1.
  - `asu_a_o`, `asu_b_o`, `asu_ci_o`, `asu_add_sub_o` are taken from requester w.
- **Datapath drive with no grant.** `asu_en_o` = 0, and all `asu_*` operand, carry and select outputs are driven to 0.
- **Capture.** On a grant edge:
  - `resp_sum_o <= asu_sum_i`, `resp_co_o <= asu_co_i`, `resp_id_o <= w`, `resp_valid_o <= 1`.
  - `ptr <= (w + 1) mod NUM_REQ`.
  - `op_count_o <= op_count_o + 1`, wrapping from 0xFFFFFFFF to 0.
- **Drain.** If `resp_valid_o && resp_ready_i` and there is no grant in the same cycle, `resp_valid_o <= 0`. The response data registers hold their last value.
- **Hold.** If there is no grant, `ptr` holds its value.
- **Requester obligations.** A requester keeps `req_valid_i` and its operands stable until it sees ready. The block does not check this.
- **Carry-out semantics.** `asu_co_i` is passed through uninterpreted for both add and subtract.
- **Reset** (asynchronous assert, synchronous release):
  - `ptr` = 0, `resp_valid_o` = 0, `resp_id_o` = 0, `resp_sum_o` = 0, `resp_co_o` = 0, `op_count_o` = 0.
  - Combinational outputs follow their rules, so `asu_en_o` = 0 and `req_ready_o` = 0 while no request is granted.
  - Reset asserted mid-stream discards the pending response; no partial state survives.

## Timing
- **Latency.** Request accepted at edge N; `resp_valid_o` is high in cycle N+1 with the result.
- **Throughput.** One operation per cycle while `resp_ready_i` is held high.
- **Simultaneous drain and grant.** When drain and a new grant occur on the same edge, the register is overwritten, `resp_valid_o` stays 1, and there is no bubble.
- **Backpressure.** With `resp_ready_i` = 0 and `resp_valid_o` = 1, all `req_ready_o` are 0, `asu_en_o` = 0, and the response outputs are stable.
- **Single requester.** With only one requester k valid, it is granted every free cycle regardless of `ptr`.
- **Combinational paths.**
  - `req_valid_i` and `resp_ready_i` to `req_ready_o` and to `asu_*`.
  - `asu_sum_i` is only registered, so there is no path from it to any output.

## Test plan
- **Reset values.** Assert `module_rst_ni` = 0 mid-transfer, with `resp_valid_o` = 1 holding sum 0x5.
  - Required: all registered outputs read 0 immediately, `asu_en_o` = 0, `op_count_o` = 0.
- **Single add.** Requester 2 only: a = 0xFFFFFFFF, b = 1, ci = 0, add.
  - Required: ready in the same cycle; next cycle `resp_valid_o` = 1, `resp_id_o` = 2, `resp_sum_o` = 0, `resp_co_o` = `asu_co_i` as captured.
- **Fairness.** All 4 requesters held valid, `resp_ready_i` = 1 constant.
  - Required: grant order 0, 1, 2, 3, 0, 1; one response per cycle; `op_count_o` increments by 1 each cycle.
- **Backpressure.** `resp_ready_i` = 0 for 5 cycles while requesters 1 and 3 are valid.
  - Required: exactly one response is captured (id 1); no further ready; `asu_en_o` = 0.
  - Then raise `resp_ready_i`: the id 3 response appears on the next cycle with no bubble.
- **Subtract path.** Requester 0: a = 10, b = 3, ci = 0, subtract.
  - Required: `asu_add_sub_o` = 1 in the grant cycle; `resp_sum_o` = 7.
  - Required: in idle cycles, all `asu_*` outputs are 0.
- **Counter wrap.** Force `op_count_o` to 0xFFFFFFFF, then complete one operation.
  - Required: `op_count_o` = 0.
